// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK with checksum,
// length and inter-byte timeout checks, plus the K factor register.
module uart_cmd_parser #(
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hA5,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         K_W         = 4,
    parameter logic [7:0] CMD_SET_K   = 8'hA6,
    parameter logic [7:0] CMD_CLR_K   = 8'hA7
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic [4:0]           cmd_len,
    output logic [8*MAX_LEN-1:0] cmd_data,
    output logic [K_W-1:0]       K,
    output logic                 err_valid,
    output logic [1:0]           err_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H1   = 3'd1,
        ST_CMD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     tmo_cnt_r;
    logic [7:0]           cmd_r;
    logic [4:0]           len_r;
    logic [4:0]           idx_r;
    logic [7:0]           sum_r;
    logic [8*MAX_LEN-1:0] shadow_r;
    logic                 len_bad_s;

    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // K is loaded with (payload byte 0 - 1), wrapping so 0 yields all-ones
    function automatic logic [K_W-1:0] k_from_byte(input logic [7:0] b);
        return b[K_W-1:0] - K_W'(1);
    endfunction

    // Oversized frames, and a set-K with no operand byte, are rejected at LEN
    always_comb begin
        len_bad_s = 1'b0;
        if ((rx_data > 8'(MAX_LEN)) || ((cmd_r == CMD_SET_K) && (rx_data == 8'd0))) begin
            len_bad_s = 1'b1;
        end else begin
            len_bad_s = 1'b0;
        end
    end

    // Frame FSM, inter-byte timeout counter and all registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
            cmd_r     <= 8'd0;
            len_r     <= 5'd0;
            idx_r     <= 5'd0;
            sum_r     <= 8'd0;
            shadow_r  <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'd0;
            cmd_len   <= 5'd0;
            cmd_data  <= '0;
            K         <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            cmd_valid <= 1'b0;
            err_valid <= 1'b0;
            if (rx_done) begin
                tmo_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: state_r <= (rx_data == HDR0) ? ST_H1 : ST_IDLE;
                    ST_H1: begin
                        if (rx_data == HDR1)      state_r <= ST_CMD;
                        else if (rx_data == HDR0) state_r <= ST_H1;
                        else                      state_r <= ST_IDLE;
                    end
                    ST_CMD: begin
                        cmd_r   <= rx_data;
                        sum_r   <= rx_data;
                        state_r <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (len_bad_s) begin
                            err_valid <= 1'b1;
                            err_code  <= 2'd2;
                            state_r   <= ST_IDLE;
                        end else begin
                            len_r    <= rx_data[4:0];
                            sum_r    <= chk_add(sum_r, rx_data);
                            shadow_r <= '0;
                            idx_r    <= 5'd0;
                            state_r  <= (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx_r == 5'(i)) shadow_r[8*i +: 8] <= rx_data;
                        end
                        sum_r   <= chk_add(sum_r, rx_data);
                        idx_r   <= idx_r + 5'd1;
                        state_r <= (idx_r == (len_r - 5'd1)) ? ST_CHK : ST_DATA;
                    end
                    ST_CHK: begin
                        if (sum_r == rx_data) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= cmd_r;
                            cmd_len   <= len_r;
                            cmd_data  <= shadow_r;
                            if (cmd_r == CMD_SET_K)      K <= k_from_byte(shadow_r[7:0]);
                            else if (cmd_r == CMD_CLR_K) K <= '0;
                            else                         K <= K;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= 2'd1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                // A byte arriving on the terminal count wins, hence this sits under !rx_done
                if (tmo_cnt_r == CNT_W'(TIMEOUT_CYC)) begin
                    err_valid <= 1'b1;
                    err_code  <= 2'd3;
                    state_r   <= ST_IDLE;
                    tmo_cnt_r <= '0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                end
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frame-level reference model feeds an
// expectation queue; a monitor checks every cmd/err pulse, its timing and outputs.
module tb_uart_cmd_parser;

    localparam int MAXL = 4;
    localparam int TC   = 20;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [7:0]      rx_data;
    logic            rx_done;
    logic            cmd_valid;
    logic [7:0]      cmd_code;
    logic [4:0]      cmd_len;
    logic [8*MAXL-1:0] cmd_data;
    logic [3:0]      K;
    logic            err_valid;
    logic [1:0]      err_code;

    uart_cmd_parser #(
        .HDR0(8'h55), .HDR1(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYC(TC),
        .K_W(4), .CMD_SET_K(8'hA6), .CMD_CLR_K(8'hA7)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .K(K), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_err;
        logic [1:0]  ecode;
        logic [7:0]  code;
        logic [4:0]  len;
        logic [31:0] data;
        logic [3:0]  k;
        longint      t;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference model of the architectural output state
    logic [7:0]  m_code;
    logic [4:0]  m_len;
    logic [31:0] m_data;
    logic [3:0]  m_k;
    logic [1:0]  m_err;
    logic [7:0]  pl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_err, input longint t);
        exp_t e;
        e.is_err = is_err; e.ecode = m_err; e.code = m_code; e.len = m_len;
        e.data = m_data; e.k = m_k; e.t = t;
        sb.push_back(e);
    endtask

    // monitor: every output pulse must match the head of the scoreboard
    always @(negedge Clk) begin
        exp_t e;
        if (cmd_valid || err_valid) begin
            chk("pulse_exclusive", {63'd0, cmd_valid & err_valid}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, cmd_valid, err_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {63'd0, err_valid}, {63'd0, e.is_err});
                chk("pulse_time", 64'($time), 64'(e.t));
                chk("err_code", {62'd0, err_code}, {62'd0, e.ecode});
                chk("cmd_code", {56'd0, cmd_code}, {56'd0, e.code});
                chk("cmd_len",  {59'd0, cmd_len},  {59'd0, e.len});
                chk("cmd_data", {32'd0, cmd_data}, {32'd0, e.data});
                chk("K",        {60'd0, K},        {60'd0, e.k});
            end
        end
    end

    // bytes are driven at a negedge and sampled on the following posedge
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge Clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_done = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] chk_delta, input bit extra55,
                              input int stall_at, input int gap_lo, input int gap_hi);
        logic [7:0] b[$];
        logic [7:0] sum;
        int         len_idx;
        bit         len_bad;
        b = {};
        if (extra55) b.push_back(8'h55);
        b.push_back(8'h55); b.push_back(8'hA5); b.push_back(cmd); b.push_back(len);
        len_idx = b.size() - 1;
        len_bad = (len > 8'(MAXL)) || (cmd == 8'hA6 && len == 8'd0);
        sum = cmd + len;
        if (!len_bad) begin
            for (int i = 0; i < int'(len); i++) begin
                b.push_back(pl[i]);
                sum = sum + pl[i];
            end
            b.push_back(sum + chk_delta);
        end
        for (int i = 0; i < b.size(); i++) begin
            if (i == stall_at) begin
                m_err = 2'd3;
                push_exp(1'b1, $time + 10 + (TC + 1) * 10);
                send_byte(b[i]);
                idle(TC + 4);
                return;
            end
            if (i == len_idx && len_bad) begin
                m_err = 2'd2;
                push_exp(1'b1, $time + 10);
                send_byte(b[i]);
                return;
            end
            if (i == b.size() - 1) begin
                if (chk_delta != 8'd0) begin
                    m_err = 2'd1;
                    push_exp(1'b1, $time + 10);
                end else begin
                    m_code = cmd;
                    m_len  = len[4:0];
                    m_data = 32'd0;
                    for (int j = 0; j < int'(len); j++) m_data[8*j +: 8] = pl[j];
                    if (cmd == 8'hA6)      m_k = pl[0][3:0] - 4'd1;
                    else if (cmd == 8'hA7) m_k = 4'd0;
                    push_exp(1'b0, $time + 10);
                end
                send_byte(b[i]);
            end else begin
                send_byte(b[i]);
                idle($urandom_range(gap_hi, gap_lo));
            end
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        rx_done = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        m_code = 8'd0; m_len = 5'd0; m_data = 32'd0; m_k = 4'd0; m_err = 2'd0;
        chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
        chk("rst_err_code",  {62'd0, err_code},  64'd0);
        chk("rst_cmd_code",  {56'd0, cmd_code},  64'd0);
        chk("rst_cmd_len",   {59'd0, cmd_len},   64'd0);
        chk("rst_cmd_data",  {32'd0, cmd_data},  64'd0);
        chk("rst_K",         {60'd0, K},         64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wait_cyc;
        logic [7:0] cmd;
        logic [7:0] nb;
        Reset_n = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'd0;
        for (int i = 0; i < 16; i++) pl[i] = 8'd0;
        @(negedge Clk);
        do_reset();

        // set K with operand 5, then operand 0 (wraps), then clear
        pl[0] = 8'h05; send_frame(8'hA6, 8'd1, 8'd0, 1'b0, -1, 0, 0);
        idle(3);
        pl[0] = 8'h00; send_frame(8'hA6, 8'd1, 8'd0, 1'b0, -1, 0, 2);
        send_frame(8'hA7, 8'd0, 8'd0, 1'b0, -1, 0, 0);
        idle(2);
        // bad checksum (CHK=00), then the good frame with CHK=45
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h10, 8'd2, 8'hBB, 1'b0, -1, 0, 0);
        send_frame(8'h10, 8'd2, 8'h00, 1'b0, -1, 0, 0);
        // oversize length, then a repeated header byte
        send_frame(8'h10, 8'd5, 8'h00, 1'b0, -1, 0, 0);
        pl[0] = 8'h09; send_frame(8'hA6, 8'd1, 8'h00, 1'b0, -1, 0, 0);
        send_frame(8'hA7, 8'd0, 8'h00, 1'b1, -1, 0, 0);
        // set-K without operand is a length error
        send_frame(8'hA6, 8'd0, 8'h00, 1'b0, -1, 0, 0);
        // stall after CMD, then gaps exactly on the terminal count
        send_frame(8'hA6, 8'd1, 8'h00, 1'b0, 2, 0, 0);
        pl[0] = 8'h03; pl[1] = 8'h44;
        send_frame(8'hA6, 8'd2, 8'h00, 1'b0, -1, TC, TC);
        idle(2);

        // randomized frames with noise, errors, stalls and gaps
        for (int f = 0; f < 60; f++) begin
            for (int n = 0; n < int'($urandom_range(2, 0)); n++) begin
                nb = 8'($urandom_range(255, 0));
                if (nb == 8'h55) nb = 8'h00;
                send_byte(nb);
            end
            case ($urandom_range(3, 0))
                0: cmd = 8'hA6;
                1: cmd = 8'hA7;
                default: cmd = 8'($urandom_range(255, 0));
            endcase
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
            send_frame(cmd, 8'($urandom_range(MAXL + 1, 0)),
                       ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
                       1'($urandom_range(1, 0)),
                       ($urandom_range(9, 0) == 0) ? int'($urandom_range(2, 0)) : -1,
                       0, ($urandom_range(1, 0) == 0) ? 0 : TC);
        end
        idle(3);

        // reset mid-payload, then a back-to-back valid frame
        send_byte(8'h55); send_byte(8'hA5); send_byte(8'hA6);
        send_byte(8'h02); send_byte(8'h07);
        do_reset();
        pl[0] = 8'h0C; pl[1] = 8'h5A;
        send_frame(8'hA6, 8'd2, 8'h00, 1'b0, -1, 0, 0);

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 200) begin
            @(negedge Clk);
            wait_cyc++;
        end
        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised UART command-frame parser between the UART receiver (`rx_data`/`rx_done`) and the sample-rate control logic. It recovers variable-length frames of the form header, command, length, payload and checksum. It verifies the length and checksum, enforces an inter-byte timeout, and presents each good frame as a one-cycle command strobe. It also keeps the decimation/interpolation factor register `K` (command 0xA6 sets it, 0xA7 clears it), extended to a parametrised width.

## Interface
- `HDR0`, 8'h55, first header byte
- `HDR1`, 8'hA5, second header byte
- `MAX_LEN`, 4, maximum payload bytes accepted (1..16)
- `TIMEOUT_CYC`, 100000, idle Clk cycles allowed between bytes inside a frame (≥2)
- `K_W`, 4, width of K register (≤8)
- `CMD_SET_K`, 8'hA6, command code that loads K
- `CMD_CLR_K`, 8'hA7, command code that clears K

Ports:
- `Clk`  in  1  system clock; one clock domain only
- `Reset_n`  in  1  reset; synchronous, active-low
- `rx_data`  in  8  received byte, valid while `rx_done`=1
- `rx_done`  in  1  one-cycle strobe per received byte
- `cmd_valid`  out  1  one-cycle pulse: good frame decoded
- `cmd_code`  out  8  command byte of the last good frame
- `cmd_len`  out  5  payload length of the last good frame
- `cmd_data`  out  8*MAX_LEN  payload; byte i on [8i+7:8i]; unused bytes 0
- `K`  out  K_W  factor register
- `err_valid`  out  1  one-cycle pulse: frame discarded
- `err_code`  out  2  1=checksum, 2=length, 3=timeout; holds until next error

## Operation
- Frame: HDR0, HDR1, CMD, LEN, PAYLOAD[LEN], CHK. CHK = (CMD + LEN + sum of payload) mod 256.
- FSM states and transitions, each advanced only on `rx_done`:
  - IDLE: byte==HDR0 goes to H1; any other byte stays in IDLE.
  - H1: byte==HDR1 goes to CMD; byte==HDR0 stays in H1; any other byte goes to IDLE.
  - CMD: latch the byte into the shadow command, seed the running sum, go to LEN.
  - LEN: if LEN>MAX_LEN, pulse err (code 2) and go to IDLE. If LEN==0, go to CHK. Otherwise clear the shadow payload, reset the byte index and go to DATA.
  - DATA: store the byte at the index and add it to the sum. Go to CHK after LEN bytes.
  - CHK: on a match, commit the shadow to `cmd_code`/`cmd_len`/`cmd_data` and pulse `cmd_valid`. On a mismatch, pulse err (code 1). Go to IDLE in both cases.
- Outputs `cmd_*` change only when a frame is committed. A bad frame never alters them.
- K update happens in the same cycle as the commit:
  - CMD_SET_K with LEN≥1: K = payload[0][K_W-1:0] − 1, mod 2^K_W. A payload of 0 gives all-ones.
  - CMD_SET_K with LEN==0: treated as a length error (code 2). No commit, K unchanged.
  - CMD_CLR_K: K = 0, regardless of payload.
  - Any other code: K holds its value.
- Timeout: the counter is cleared on every `rx_done` and in IDLE. It increments in every other state. When it reaches TIMEOUT_CYC, pulse err (code 3) and go to IDLE.
- Priority: `rx_done` in the same cycle as the timeout terminal count means the byte is processed and the timeout is not taken.
- `cmd_valid` and `err_valid` are never high in the same cycle.

## Timing
- All outputs are registered.
- `cmd_valid`/`err_valid` rise exactly one Clk cycle after the `rx_done` of the CHK byte (or of the offending LEN byte) and last 1 cycle.
- Timeout error: `err_valid` rises the cycle after the counter hits TIMEOUT_CYC, i.e. TIMEOUT_CYC+1 cycles after the last `rx_done`.
- Back-to-back `rx_done` on consecutive cycles is supported: one byte per cycle with no loss.
- A new HDR0 received in the cycle after a CHK byte is accepted.
- Reset (`Reset_n`=0 at a Clk edge) sets:
  - state = IDLE, counter = 0
  - `cmd_valid`=0, `err_valid`=0, `err_code`=0
  - `cmd_code`=0, `cmd_len`=0, `cmd_data`=0, `K`=0
- Reset mid-frame discards the partial frame and produces no error pulse.

## Test plan
- Send 55 A5 A6 01 05 AC → `cmd_valid` 1 cycle after the last byte, `cmd_code`=A6, `cmd_len`=1, `cmd_data`[7:0]=05, K=4.
- Send 55 A5 A6 01 00 A7, then 55 A5 A7 00 A7 → K=F after the first frame, K=0 after the second, two `cmd_valid` pulses.
- Send 55 A5 10 02 11 22 00 (bad checksum) → `err_valid` with code 1; `cmd_*` and K unchanged. Resend with CHK=45 → commit with `cmd_data`[15:0]=2211.
- Send 55 A5 10 05 (MAX_LEN=4) → err code 2 right after the LEN byte. Then send 55 55 A5 A7 00 A7 → K=0 and commit; the repeated header byte is tolerated.
- Stall TIMEOUT_CYC cycles after 55 A5 A6 → err code 3, FSM back in IDLE. Also assert `rx_done` exactly on the terminal count → no timeout, frame continues.
- Assert `Reset_n`=0 mid-payload, then send a full valid frame with back-to-back `rx_done` → all outputs 0 after reset, no err pulse, correct commit.
